// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller between the PC register, the
// instruction bus and the fetch-to-decode register.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   pc                  current fetch PC (to pcselect)
//   pcplus4             pc+4 from pcselect, combinational from pc
//   ireq_valid/addr     instruction-bus request
//   iresp_data_ok/data  instruction-bus response, completes the request
//   redirect_valid/pc   one-cycle branch/exception redirect
//   f_valid/pc/instr    fetch-to-decode register
//   d_ready             decode accepts f_* this cycle
//
// state   | meaning
// --------+------------------------------------------------------------
// FETCH   | request at pc outstanding on the bus
// HOLD    | fetched word parked in hold buffer, decode slot full, no request
// DISCARD | request abandoned by a redirect, waiting to drop its response
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] pc,
  input  logic [63:0] pcplus4,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr,
  input  logic        d_ready
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] hold_pc;
  logic [31:0] hold_instr;
  logic [63:0] saved_addr;
  logic        slot_free;

  assign slot_free = !f_valid || d_ready;

  // Gated with reset so no request is ever visible in a reset cycle.
  assign ireq_valid = !reset && (state != HOLD);

  // DISCARD keeps presenting the abandoned address: the bus requires the
  // address to stay put until the response arrives.
  assign ireq_addr = (state == DISCARD) ? saved_addr : pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      f_valid    <= 1'b0;
      f_pc       <= '0;
      f_instr    <= '0;
      hold_pc    <= '0;
      hold_instr <= '0;
      saved_addr <= '0;
    end else if (redirect_valid) begin
      // Redirect wins over everything: whatever was fetched or buffered is
      // dropped; only the outstanding bus request needs bookkeeping.
      f_valid <= 1'b0;
      pc      <= redirect_pc;
      case (state)
        FETCH: begin
          if (!iresp_data_ok) begin
            saved_addr <= pc;
            state      <= DISCARD;
          end
        end
        HOLD:    state <= FETCH;
        DISCARD: if (iresp_data_ok) state <= FETCH;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (iresp_data_ok) begin
            if (slot_free) begin
              f_valid <= 1'b1;
              f_pc    <= pc;
              f_instr <= iresp_data;
              pc      <= pcplus4;
            end else begin
              // pc is held so pcplus4 is still correct when the buffer drains.
              hold_pc    <= pc;
              hold_instr <= iresp_data;
              state      <= HOLD;
            end
          end else if (d_ready) begin
            f_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (d_ready) begin
            f_valid <= 1'b1;
            f_pc    <= hold_pc;
            f_instr <= hold_instr;
            pc      <= pcplus4;
            state   <= FETCH;
          end
        end
        DISCARD: begin
          if (iresp_data_ok) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios followed by random traffic, all checked
// against a queue-based model of the fetch pipeline.
module tb_fetch_ctrl;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk;
  logic        reset;
  logic [63:0] pc;
  logic [63:0] pcplus4;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_instr;
  logic        d_ready;

  int total = 0;
  int bad   = 0;

  // Model: delivered-but-not-consumed instructions (head is the decode
  // register, a second entry means it is parked), plus addresses of
  // requests abandoned by a redirect whose responses must be dropped.
  logic [63:0] q_pc[$];
  logic [31:0] q_instr[$];
  logic [63:0] stale[$];
  logic [63:0] m_pc;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .pcplus4        (pcplus4),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_instr        (f_instr),
    .d_ready        (d_ready)
  );

  // pcselect stand-in
  assign pcplus4 = pc + 64'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_req_valid();
    return !reset && (stale.size() > 0 || q_pc.size() < 2);
  endfunction

  function automatic logic [63:0] m_exp_pc();
    return (q_pc.size() == 2) ? q_pc[1] : m_pc;
  endfunction

  task automatic model_update();
    logic had_two;
    logic discarding;
    if (reset) begin
      q_pc.delete();
      q_instr.delete();
      stale.delete();
      m_pc = RESET_PC;
    end else if (redirect_valid) begin
      if (stale.size() > 0) begin
        if (iresp_data_ok) void'(stale.pop_front());
      end else if (q_pc.size() < 2 && !iresp_data_ok) begin
        stale.push_back(m_pc);
      end
      q_pc.delete();
      q_instr.delete();
      m_pc = redirect_pc;
    end else begin
      had_two    = (q_pc.size() == 2);
      discarding = (stale.size() > 0);
      if (q_pc.size() > 0 && d_ready) begin
        void'(q_pc.pop_front());
        void'(q_instr.pop_front());
      end
      if (discarding) begin
        if (iresp_data_ok) void'(stale.pop_front());
      end else if (!had_two && iresp_data_ok) begin
        q_pc.push_back(m_pc);
        q_instr.push_back(iresp_data);
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  task automatic model_check();
    logic exp_v;
    exp_v = m_req_valid();
    chk("ireq_valid", {63'd0, ireq_valid}, {63'd0, exp_v});
    if (exp_v) chk("ireq_addr", ireq_addr, (stale.size() > 0) ? stale[0] : m_pc);
    chk("pc", pc, m_exp_pc());
    chk("f_valid", {63'd0, f_valid}, {63'd0, q_pc.size() > 0});
    if (q_pc.size() > 0) begin
      chk("f_pc", f_pc, q_pc[0]);
      chk("f_instr", {32'd0, f_instr}, {32'd0, q_instr[0]});
    end
  endtask

  // One cycle: retire the previous edge into the model, drive this cycle's
  // inputs, then compare. Callers may add checks for the same cycle after.
  task automatic step(input logic rst, input logic rdv, input logic [63:0] rdpc,
                      input logic dok, input logic dr);
    @(posedge clk);
    model_update();
    @(negedge clk);
    reset          = rst;
    redirect_valid = rdv;
    redirect_pc    = rdpc;
    d_ready        = dr;
    iresp_data     = $urandom;
    iresp_data_ok  = dok && m_req_valid();
    #1;
    model_check();
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    d_ready        = 1'b0;
    m_pc           = RESET_PC;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);

    // back-to-back fetch out of reset
    step(0, 0, 0, 1, 1);
    chk("rst_f_valid", {63'd0, f_valid}, 64'd0);
    chk("rst_f_pc", f_pc, 64'd0);
    chk("rst_f_instr", {32'd0, f_instr}, 64'd0);
    chk("first_addr", ireq_addr, 64'h8000_0000);
    step(0, 0, 0, 1, 1);
    chk("b2b_f_pc0", f_pc, 64'h8000_0000);
    step(0, 0, 0, 1, 1);
    chk("b2b_f_pc1", f_pc, 64'h8000_0004);
    step(0, 0, 0, 0, 1);
    chk("b2b_f_pc2", f_pc, 64'h8000_0008);

    // stall into HOLD, then reset while holding
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    chk("pre_hold_f_pc", f_pc, 64'h8000_0000);
    step(0, 0, 0, 0, 0);
    chk("hold_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("hold_f_pc", f_pc, 64'h8000_0000);
    step(1, 0, 0, 0, 0);
    chk("hold_rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    step(0, 0, 0, 1, 1);
    chk("post_rst_f_valid", {63'd0, f_valid}, 64'd0);
    chk("post_rst_addr", ireq_addr, 64'h8000_0000);

    // HOLD drains on d_ready
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    chk("hold2_f_pc", f_pc, 64'h8000_0000);
    step(0, 1, 64'h8000_0100, 0, 1);
    chk("drain_f_pc", f_pc, 64'h8000_0004);
    chk("drain_addr", ireq_addr, 64'h8000_0008);

    // redirect with request pending: address holds until data_ok
    step(0, 0, 0, 0, 1);
    chk("disc_addr0", ireq_addr, 64'h8000_0008);
    chk("disc_f_valid", {63'd0, f_valid}, 64'd0);
    step(0, 0, 0, 1, 1);
    chk("disc_addr1", ireq_addr, 64'h8000_0008);
    step(0, 0, 0, 1, 1);
    chk("redir_addr", ireq_addr, 64'h8000_0100);
    chk("redir_f_valid", {63'd0, f_valid}, 64'd0);

    // redirect coincident with data_ok and stalled decode
    step(0, 1, 64'h8000_0200, 1, 0);
    chk("same_cyc_f_pc", f_pc, 64'h8000_0100);
    step(0, 1, 64'h8000_0280, 0, 1);
    chk("same_cyc_f_valid", {63'd0, f_valid}, 64'd0);
    chk("same_cyc_addr", ireq_addr, 64'h8000_0200);

    // two further redirects while discarding
    step(0, 1, 64'h8000_0300, 0, 1);
    step(0, 1, 64'h8000_0400, 0, 1);
    chk("multi_disc_addr", ireq_addr, 64'h8000_0200);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    chk("multi_redir_addr", ireq_addr, 64'h8000_0400);

    // PC wrap at 2^64
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("wrap_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 0, 1);
    chk("wrap_f_pc", f_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc", pc, 64'd0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(63) == 0,
           $urandom_range(7) == 0,
           {32'd0, 32'h8000_0000 | ($urandom & 32'h0000_fffc)},
           $urandom_range(1) == 1,
           $urandom_range(2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000, PC loaded on reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pc  out  64  current fetch PC, consumed by pcselect.
REQ-005 pcplus4  in  64  pc+4 returned by pcselect (combinational from pc).
REQ-006 ireq_valid  out  1  instruction-bus request valid.
REQ-007 ireq_addr  out  64  instruction-bus request address.
REQ-008 iresp_data_ok  in  1  response handshake; completes current request this cycle.
REQ-009 iresp_data  in  32  instruction word, valid with iresp_data_ok.
REQ-010 redirect_valid  in  1  branch/exception redirect, one-cycle pulse.
REQ-011 redirect_pc  in  64  redirect target.
REQ-012 f_valid  out  1  fetch-to-decode register valid.
REQ-013 f_pc  out  64  PC of delivered instruction.
REQ-014 f_instr  out  32  delivered instruction.
REQ-015 d_ready  in  1  decode accepts f_* this cycle when f_valid=1.

Function
REQ-016 States SHALL be FETCH, HOLD, DISCARD; reset state FETCH.
REQ-017 FETCH: ireq_valid=1, ireq_addr=pc; HOLD: ireq_valid=0; DISCARD: ireq_valid=1, ireq_addr=saved addr of abandoned request.
REQ-018 Once ireq_valid=1, ireq_addr SHALL stay stable until the cycle iresp_data_ok=1 (bus rule), including across redirects.
REQ-019 Output slot free := f_valid=0 or d_ready=1.
REQ-020 FETCH, data_ok=1, no redirect, slot free: f_valid<=1, f_pc<=pc, f_instr<=iresp_data, pc<=pcplus4, stay FETCH (back-to-back, 1 instr/cycle max).
REQ-021 FETCH, data_ok=1, no redirect, slot not free: {pc,iresp_data} into hold buffer, go HOLD; f_* unchanged.
REQ-022 FETCH, data_ok=0, no redirect: stay FETCH; if d_ready=1 then f_valid<=0.
REQ-023 HOLD, d_ready=1, no redirect: f_* <= hold buffer, f_valid<=1, pc<=pcplus4, go FETCH; d_ready=0: stay HOLD.
REQ-024 Redirect SHALL have priority over every other event in the same cycle: f_valid<=0, pc<=redirect_pc, any fetched/buffered instruction dropped.
REQ-025 Redirect in FETCH with data_ok=0: save ireq_addr, go DISCARD; with data_ok=1: drop data, stay FETCH.
REQ-026 Redirect in HOLD: drop buffer, go FETCH.
REQ-027 DISCARD: on data_ok=1 drop data, go FETCH (next request uses redirected pc); redirect in DISCARD updates pc, stays DISCARD (or FETCH if data_ok=1).
REQ-028 f_valid SHALL remain 0 while in DISCARD; an instruction from a pre-redirect request SHALL never reach f_*.
REQ-029 f_pc/f_instr SHALL hold stable while f_valid=1 and d_ready=0.
REQ-030 PC arithmetic is 64-bit, wraps modulo 2^64 (taken from pcplus4); no alignment checking.

Reset
REQ-031 On reset: pc=RESET_PC, state FETCH, f_valid=0, f_pc=0, f_instr=0, hold buffer cleared, saved address 0.
REQ-032 ireq_valid SHALL be 0 in any cycle reset=1; first request (addr RESET_PC) in the first cycle after reset deasserts.
REQ-033 Reset mid-request SHALL abandon the request; a data_ok arriving during or after reset for it is ignored only if in DISCARD, otherwise bus is assumed reset together.

Verification
REQ-034 Reset release, data_ok every cycle, d_ready=1 -> f_pc 8000_0000, 8000_0004, 8000_0008 on consecutive cycles, instr matches.
REQ-035 f_valid=1, d_ready=0, data_ok for 8000_0004 -> HOLD, ireq_valid=0, f_pc stays 8000_0000; d_ready=1 -> f_pc=8000_0004, next ireq_addr 8000_0008.
REQ-036 Request to 8000_0008 pending, redirect to 8000_0100 with data_ok=0 -> ireq_addr stays 8000_0008 until data_ok, data dropped, then ireq_addr=8000_0100, f_valid=0 meanwhile.
REQ-037 Redirect to 8000_0200 same cycle as data_ok and d_ready=0 -> f_valid=0 next cycle, state FETCH, ireq_addr=8000_0200.
REQ-038 Two redirects (8000_0300 then 8000_0400) during DISCARD -> after data_ok, first request is 8000_0400.
REQ-039 Assert reset in HOLD with f_valid=1 -> next cycle f_valid=0, ireq_valid=0; after release ireq_addr=8000_0000.
